// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the pipeline hazard/control unit: forward-select codes,
// FSM states and the forward-priority helper.
package hazard_ctrl_unit_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int STALL_CNT_BITS = 3;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HALTED  = 1'b1
  } state_t;

  // EX has priority over MEM; a load in EX has no result yet, so it never forwards
  // and the MEM path is not consulted for that operand either.
  function automatic logic [1:0] fwd_select(input logic rel_ex, input logic ex_load,
                                            input logic rel_mem);
    if (rel_ex)       return ex_load ? FWD_REG : FWD_EX;
    else if (rel_mem) return FWD_MEM;
    else              return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_detect.sv
// ID-stage RAW relation detection and operand forward selection (purely combinational).
module hazard_ctrl_unit_detect #(
  parameter int REG_BITS = 5,
  parameter int FWD_EN   = 1
) (
  input  logic                id_r1_used,
  input  logic                id_r2_used,
  input  logic [REG_BITS-1:0] id_r1_no,
  input  logic [REG_BITS-1:0] id_r2_no,
  input  logic                ex_reg_write,
  input  logic                ex_mem_to_reg,
  input  logic [REG_BITS-1:0] ex_write_reg,
  input  logic                mem_reg_write,
  input  logic [REG_BITS-1:0] mem_write_reg,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                raw_stall
);
  import hazard_ctrl_unit_pkg::*;

  logic r1_ex, r2_ex, r1_mem, r2_mem;

  assign r1_ex  = id_r1_used & ex_reg_write  & (ex_write_reg  == id_r1_no) & (id_r1_no != '0);
  assign r2_ex  = id_r2_used & ex_reg_write  & (ex_write_reg  == id_r2_no) & (id_r2_no != '0);
  assign r1_mem = id_r1_used & mem_reg_write & (mem_write_reg == id_r1_no) & (id_r1_no != '0);
  assign r2_mem = id_r2_used & mem_reg_write & (mem_write_reg == id_r2_no) & (id_r2_no != '0);

  // Forward selection and raw stall request; without forwarding every RAW hazard stalls
  always_comb begin
    fwd_a     = FWD_REG;
    fwd_b     = FWD_REG;
    raw_stall = 1'b0;
    if (FWD_EN != 0) begin
      fwd_a     = fwd_select(r1_ex, ex_mem_to_reg, r1_mem);
      fwd_b     = fwd_select(r2_ex, ex_mem_to_reg, r2_mem);
      raw_stall = ex_mem_to_reg & (r1_ex | r2_ex);
    end else begin
      raw_stall = r1_ex | r2_ex | r1_mem | r2_mem;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline control for the 5-stage MIPS CPU: load-use stall, branch flush,
// halt/go FSM and performance counters.
module hazard_ctrl_unit #(
  parameter int REG_BITS     = 5,
  parameter int CNT_WIDTH    = 32,
  parameter int LOAD_BUBBLES = 1,
  parameter int FWD_EN       = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 id_r1_used,
  input  logic                 id_r2_used,
  input  logic [REG_BITS-1:0]  id_r1_no,
  input  logic [REG_BITS-1:0]  id_r2_no,
  input  logic                 ex_reg_write,
  input  logic                 ex_mem_to_reg,
  input  logic [REG_BITS-1:0]  ex_write_reg,
  input  logic                 mem_reg_write,
  input  logic [REG_BITS-1:0]  mem_write_reg,
  input  logic                 ex_cond_taken,
  input  logic                 ex_uncond,
  input  logic                 wb_halt,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic                 pc_enable,
  output logic                 ifid_enable,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] total_cycles,
  output logic [CNT_WIDTH-1:0] condi_branch_num,
  output logic [CNT_WIDTH-1:0] uncondi_branch_num,
  output logic [CNT_WIDTH-1:0] bubble_num
);
  import hazard_ctrl_unit_pkg::*;

  localparam logic [STALL_CNT_BITS-1:0] RELOAD  = STALL_CNT_BITS'(LOAD_BUBBLES - 1);
  localparam logic [CNT_WIDTH-1:0]      CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                    state;
  logic                      go_d;
  logic                      go_rise;
  logic [STALL_CNT_BITS-1:0] stall_cnt;
  logic                      raw_stall;
  logic                      stall;
  logic                      flush;

  hazard_ctrl_unit_detect #(
    .REG_BITS (REG_BITS),
    .FWD_EN   (FWD_EN)
  ) u_detect (
    .id_r1_used    (id_r1_used),
    .id_r2_used    (id_r2_used),
    .id_r1_no      (id_r1_no),
    .id_r2_no      (id_r2_no),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_write_reg  (ex_write_reg),
    .mem_reg_write (mem_reg_write),
    .mem_write_reg (mem_write_reg),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .raw_stall     (raw_stall)
  );

  assign go_rise = go & ~go_d;
  assign stall   = raw_stall | (stall_cnt != '0);
  assign flush   = ex_cond_taken | ex_uncond;
  assign halted  = (state == ST_HALTED);

  // Pipeline enables: halt freezes the front end, a redirect beats a stall
  always_comb begin
    pc_enable   = 1'b1;
    ifid_enable = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (state == ST_HALTED) begin
      pc_enable   = 1'b0;
      ifid_enable = 1'b0;
    end else if (flush) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (stall) begin
      pc_enable   = 1'b0;
      ifid_enable = 1'b0;
      idex_flush  = 1'b1;
    end
  end

  // Halt/go FSM; go is edge-detected so a held level resumes only once
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_RUN;
      go_d  <= 1'b0;
    end else begin
      go_d <= go;
      case (state)
        ST_RUN:    if (wb_halt) state <= ST_HALTED;
        ST_HALTED: if (go_rise) state <= ST_RUN;
        default:   state <= ST_RUN;
      endcase
    end
  end

  // Extra-bubble counter: a detection only arms it when idle, redirect clears it
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (state == ST_RUN) begin
      if (flush)                stall_cnt <= '0;
      else if (stall_cnt != '0) stall_cnt <= stall_cnt - 1'b1;
      else if (raw_stall)       stall_cnt <= RELOAD;
    end
  end

  // Performance counters; frozen while halted except the resume cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      total_cycles       <= '0;
      condi_branch_num   <= '0;
      uncondi_branch_num <= '0;
      bubble_num         <= '0;
    end else if (state == ST_RUN) begin
      total_cycles <= total_cycles + CNT_ONE;
      if (ex_uncond)          uncondi_branch_num <= uncondi_branch_num + CNT_ONE;
      else if (ex_cond_taken) condi_branch_num   <= condi_branch_num + CNT_ONE;
      if (stall && !flush)    bubble_num         <= bubble_num + CNT_ONE;
    end else if (go_rise) begin
      total_cycles <= total_cycles + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two configurations (forwarding with 3 load bubbles and
// 32-bit counters; no forwarding with 1 bubble and 4-bit counters) driven in parallel.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst, go, id_r1_used, id_r2_used;
  logic [4:0] id_r1_no, id_r2_no, ex_write_reg, mem_write_reg;
  logic       ex_reg_write, ex_mem_to_reg, mem_reg_write;
  logic       ex_cond_taken, ex_uncond, wb_halt;

  logic [1:0]  a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b;
  logic        a_pc_enable, a_ifid_enable, a_ifid_flush, a_idex_flush, a_halted;
  logic        b_pc_enable, b_ifid_enable, b_ifid_flush, b_idex_flush, b_halted;
  logic [31:0] a_total_cycles, a_condi_branch_num, a_uncondi_branch_num, a_bubble_num;
  logic [3:0]  b_total_cycles, b_condi_branch_num, b_uncondi_branch_num, b_bubble_num;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_BITS(5), .CNT_WIDTH(32), .LOAD_BUBBLES(3), .FWD_EN(1)) dut_a (
    .clk(clk), .rst(rst), .go(go),
    .id_r1_used(id_r1_used), .id_r2_used(id_r2_used), .id_r1_no(id_r1_no), .id_r2_no(id_r2_no),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_write_reg(ex_write_reg),
    .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
    .ex_cond_taken(ex_cond_taken), .ex_uncond(ex_uncond), .wb_halt(wb_halt),
    .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .pc_enable(a_pc_enable), .ifid_enable(a_ifid_enable),
    .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush), .halted(a_halted),
    .total_cycles(a_total_cycles), .condi_branch_num(a_condi_branch_num),
    .uncondi_branch_num(a_uncondi_branch_num), .bubble_num(a_bubble_num)
  );

  hazard_ctrl_unit #(.REG_BITS(5), .CNT_WIDTH(4), .LOAD_BUBBLES(1), .FWD_EN(0)) dut_b (
    .clk(clk), .rst(rst), .go(go),
    .id_r1_used(id_r1_used), .id_r2_used(id_r2_used), .id_r1_no(id_r1_no), .id_r2_no(id_r2_no),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_write_reg(ex_write_reg),
    .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
    .ex_cond_taken(ex_cond_taken), .ex_uncond(ex_uncond), .wb_halt(wb_halt),
    .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .pc_enable(b_pc_enable), .ifid_enable(b_ifid_enable),
    .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush), .halted(b_halted),
    .total_cycles(b_total_cycles), .condi_branch_num(b_condi_branch_num),
    .uncondi_branch_num(b_uncondi_branch_num), .bubble_num(b_bubble_num)
  );

  // Reference model state, one entry per configuration
  int              cfg_bubbles [2] = '{3, 1};
  bit              cfg_fwd     [2] = '{1'b1, 1'b0};
  longint unsigned cfg_mask    [2] = '{64'hFFFF_FFFF, 64'hF};
  bit              m_halted    [2];
  bit              m_go_prev   [2];
  int              m_owed      [2];   // bubbles still owed beyond the current cycle
  longint unsigned m_cyc [2], m_cb [2], m_ub [2], m_bub [2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit rel(input logic used, input logic wr, input logic [4:0] wreg,
                             input logic [4:0] rno);
    return used && wr && (wreg == rno) && (rno != 0);
  endfunction

  function automatic logic [1:0] model_fwd(input int c, input bit e, input bit m);
    if (!cfg_fwd[c]) return 2'd0;
    if (e)           return ex_mem_to_reg ? 2'd0 : 2'd1;
    return m ? 2'd2 : 2'd0;
  endfunction

  function automatic bit model_hazard(input int c);
    bit e1, e2, m1, m2;
    e1 = rel(id_r1_used, ex_reg_write, ex_write_reg, id_r1_no);
    e2 = rel(id_r2_used, ex_reg_write, ex_write_reg, id_r2_no);
    m1 = rel(id_r1_used, mem_reg_write, mem_write_reg, id_r1_no);
    m2 = rel(id_r2_used, mem_reg_write, mem_write_reg, id_r2_no);
    if (cfg_fwd[c]) return ex_mem_to_reg && (e1 || e2);
    return e1 || e2 || m1 || m2;
  endfunction

  // {fwd_a, fwd_b, pc_enable, ifid_enable, ifid_flush, idex_flush, halted}
  function automatic logic [8:0] model_ctl(input int c);
    logic [1:0] fa, fb;
    logic [3:0] pipe;
    bit stalled;
    fa = model_fwd(c, rel(id_r1_used, ex_reg_write, ex_write_reg, id_r1_no),
                      rel(id_r1_used, mem_reg_write, mem_write_reg, id_r1_no));
    fb = model_fwd(c, rel(id_r2_used, ex_reg_write, ex_write_reg, id_r2_no),
                      rel(id_r2_used, mem_reg_write, mem_write_reg, id_r2_no));
    stalled = model_hazard(c) || (m_owed[c] > 0);
    if (m_halted[c])                    pipe = 4'b0000;
    else if (ex_cond_taken || ex_uncond) pipe = 4'b1111;
    else if (stalled)                   pipe = 4'b0001;
    else                                pipe = 4'b1100;
    return {fa, fb, pipe, m_halted[c]};
  endfunction

  task automatic model_advance(input int c);
    bit redirect, stalled;
    redirect = ex_cond_taken || ex_uncond;
    stalled  = model_hazard(c) || (m_owed[c] > 0);
    if (!rst) begin
      m_halted[c] = 0; m_go_prev[c] = 0; m_owed[c] = 0;
      m_cyc[c] = 0; m_cb[c] = 0; m_ub[c] = 0; m_bub[c] = 0;
      return;
    end
    if (m_halted[c]) begin
      if (go && !m_go_prev[c]) begin
        m_halted[c] = 0;
        m_cyc[c]++;
      end
    end else begin
      m_cyc[c]++;
      if (ex_uncond)          m_ub[c]++;
      else if (ex_cond_taken) m_cb[c]++;
      if (stalled && !redirect) m_bub[c]++;
      if (redirect)           m_owed[c] = 0;
      else if (m_owed[c] > 0) m_owed[c]--;
      else if (stalled)       m_owed[c] = cfg_bubbles[c] - 1;
      if (wb_halt) m_halted[c] = 1;
    end
    m_go_prev[c] = go;
  endtask

  // One clock: compare both DUTs against the model on the falling edge, then advance
  task automatic step();
    logic [8:0]  obs_ctl [2];
    logic [63:0] obs_cnt [2][4];
    @(negedge clk);
    obs_ctl[0] = {a_fwd_a, a_fwd_b, a_pc_enable, a_ifid_enable, a_ifid_flush, a_idex_flush, a_halted};
    obs_ctl[1] = {b_fwd_a, b_fwd_b, b_pc_enable, b_ifid_enable, b_ifid_flush, b_idex_flush, b_halted};
    obs_cnt[0] = '{64'(a_total_cycles), 64'(a_condi_branch_num), 64'(a_uncondi_branch_num), 64'(a_bubble_num)};
    obs_cnt[1] = '{64'(b_total_cycles), 64'(b_condi_branch_num), 64'(b_uncondi_branch_num), 64'(b_bubble_num)};
    for (int c = 0; c < 2; c++) begin
      check_eq($sformatf("ctl%0d", c), 64'(obs_ctl[c]), 64'(model_ctl(c)));
      check_eq($sformatf("cycles%0d", c),  obs_cnt[c][0], m_cyc[c] & cfg_mask[c]);
      check_eq($sformatf("condbr%0d", c),  obs_cnt[c][1], m_cb[c]  & cfg_mask[c]);
      check_eq($sformatf("uncondbr%0d", c), obs_cnt[c][2], m_ub[c] & cfg_mask[c]);
      check_eq($sformatf("bubbles%0d", c), obs_cnt[c][3], m_bub[c] & cfg_mask[c]);
    end
    for (int c = 0; c < 2; c++) model_advance(c);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1; go = 0; wb_halt = 0; ex_cond_taken = 0; ex_uncond = 0;
    id_r1_used = 0; id_r2_used = 0; id_r1_no = 0; id_r2_no = 0;
    ex_reg_write = 0; ex_mem_to_reg = 0; ex_write_reg = 0;
    mem_reg_write = 0; mem_write_reg = 0;
  endtask

  initial begin
    logic [31:0] snap_bub, snap_unc, snap_cyc;
    int stalls;

    for (int c = 0; c < 2; c++) begin
      m_halted[c] = 0; m_go_prev[c] = 0; m_owed[c] = 0;
      m_cyc[c] = 0; m_cb[c] = 0; m_ub[c] = 0; m_bub[c] = 0;
    end

    // Reset for two cycles
    idle();
    rst = 0;
    step();
    step();
    rst = 1;
    #2;
    check_eq("reset_cycles", 64'(a_total_cycles), 64'd0);
    check_eq("reset_halted", 64'(a_halted), 64'd0);
    check_eq("reset_pc_en", 64'(a_pc_enable), 64'd1);
    check_eq("reset_fwd", 64'({a_fwd_a, a_fwd_b}), 64'd0);
    step();

    // EX forward beats MEM; register 0 never forwards
    ex_reg_write = 1; ex_write_reg = 8; mem_reg_write = 1; mem_write_reg = 8;
    id_r1_used = 1; id_r1_no = 8;
    #2;
    check_eq("fwd_ex_prio", 64'(a_fwd_a), 64'd1);
    step();
    id_r1_no = 0;
    #2;
    check_eq("fwd_zero_reg", 64'(a_fwd_a), 64'd0);
    step();

    // Load-use with three bubbles
    idle();
    snap_bub = a_bubble_num;
    ex_reg_write = 1; ex_mem_to_reg = 1; ex_write_reg = 9; id_r2_used = 1; id_r2_no = 9;
    stalls = 0;
    #2;
    if (!a_pc_enable) stalls++;
    step();
    idle();
    for (int i = 0; i < 5; i++) begin
      #2;
      if (!a_pc_enable) stalls++;
      step();
    end
    check_eq("load_use_stalls", 64'(stalls), 64'd3);
    check_eq("load_use_bubbles", 64'(a_bubble_num - snap_bub), 64'd3);

    // Redirect during a stall
    ex_reg_write = 1; ex_mem_to_reg = 1; ex_write_reg = 9; id_r1_used = 1; id_r1_no = 9;
    step();
    idle();
    ex_uncond = 1;
    #2;
    snap_bub = a_bubble_num;
    snap_unc = a_uncondi_branch_num;
    check_eq("flush_flags", 64'({a_ifid_flush, a_idex_flush, a_pc_enable}), 64'b111);
    step();
    idle();
    #2;
    check_eq("flush_no_bubble", 64'(a_bubble_num), 64'(snap_bub));
    check_eq("flush_uncond_cnt", 64'(a_uncondi_branch_num), 64'(snap_unc + 32'd1));
    check_eq("flush_clears_stall", 64'(a_pc_enable), 64'd1);
    step();

    // Halt, hold, single resume on a long go level
    wb_halt = 1;
    step();
    wb_halt = 0;
    #2;
    check_eq("halt_entered", 64'(a_halted), 64'd1);
    snap_cyc = a_total_cycles;
    for (int i = 0; i < 10; i++) step();
    check_eq("halt_frozen", 64'(a_total_cycles), 64'(snap_cyc));
    go = 1;
    for (int i = 0; i < 5; i++) step();
    go = 0;
    #2;
    check_eq("resume_halted", 64'(a_halted), 64'd0);
    check_eq("resume_cycles", 64'(a_total_cycles), 64'(snap_cyc + 32'd5));
    step();

    // No-forward MEM hazard, reset while both configurations are stalled
    mem_reg_write = 1; mem_write_reg = 4; id_r2_used = 1; id_r2_no = 4;
    ex_reg_write = 1; ex_mem_to_reg = 1; ex_write_reg = 5; id_r1_used = 1; id_r1_no = 5;
    #2;
    check_eq("nofwd_stall", 64'({b_pc_enable, b_fwd_b}), 64'd0);
    step();
    rst = 0;
    step();
    idle();
    #2;
    check_eq("reset_mid_stall", 64'({a_pc_enable, b_pc_enable, a_halted}), 64'b110);
    check_eq("reset_mid_stall_bub", 64'(b_bubble_num), 64'd0);
    step();

    // Reset while halted
    wb_halt = 1;
    step();
    wb_halt = 0; rst = 0;
    step();
    rst = 1;
    #2;
    check_eq("reset_mid_halt", 64'(a_halted), 64'd0);
    step();

    // Randomized traffic; the 4-bit counters wrap many times
    for (int i = 0; i < 3000; i++) begin
      int br;
      rst          = ($urandom_range(0, 99) != 0);
      go           = ($urandom_range(0, 3) == 0);
      wb_halt      = ($urandom_range(0, 19) == 0);
      br           = $urandom_range(0, 7);
      ex_cond_taken = (br == 0) || (br == 2);
      ex_uncond    = (br == 1) || (br == 2);
      id_r1_used   = $urandom_range(0, 1);
      id_r2_used   = $urandom_range(0, 1);
      id_r1_no     = 5'($urandom_range(0, 3));
      id_r2_no     = 5'($urandom_range(0, 3));
      ex_reg_write = $urandom_range(0, 1);
      ex_mem_to_reg = ex_reg_write && ($urandom_range(0, 2) == 0);
      ex_write_reg = 5'($urandom_range(0, 3));
      mem_reg_write = $urandom_range(0, 1);
      mem_write_reg = 5'($urandom_range(0, 3));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
